// File: rtl/freq_smoother.sv
// freq_smoother: moving-average frequency filter with hysteresis and LCD-busy aware update strobe
module freq_smoother #(
  parameter int              WIDTH      = 16,
  parameter int              LOG2_DEPTH = 2,
  parameter int              HYST       = 2,
  parameter logic [23:0]     TIMEOUT    = 24'd5_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] freq_in,
  input  logic             freq_valid,
  input  logic             lcd_busy,
  output logic [WIDTH-1:0] freq_out,
  output logic             update,
  output logic             filled
);
  localparam int                  DEPTH   = 1 << LOG2_DEPTH;
  localparam int                  SW      = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] C_DEPTH = (LOG2_DEPTH+1)'(DEPTH);
  localparam logic [WIDTH-1:0]    C_HYST  = WIDTH'(HYST);

  typedef enum logic [2:0] {IDLE, SUM, CMP, WAIT, EMIT} state_t;

  state_t                r_state, w_next;
  logic [WIDTH-1:0]      r_buf [DEPTH];
  logic [SW-1:0]         r_sum;
  logic [LOG2_DEPTH:0]   r_count;
  logic [LOG2_DEPTH-1:0] r_wr;
  logic [WIDTH-1:0]      r_samp, r_skid_val, r_shown, r_pend_val, r_freq_out;
  logic                  r_skid_full, r_pend, r_filled;
  logic [23:0]           r_tmo;

  logic                  w_tmo, w_valid, w_accept, w_take, w_full, w_zero, w_has, w_trig, w_pend_any;
  logic [WIDTH-1:0]      w_din, w_take_val, w_avg, w_target, w_diff, w_pend_nxt;

  // Silence injection only runs while something non-zero is displayed; a real strobe beats it.
  assign w_tmo      = !freq_valid && r_shown != '0 && r_tmo == TIMEOUT - 24'd1;
  assign w_valid    = freq_valid || w_tmo;
  assign w_din      = freq_valid ? freq_in : '0;
  assign w_accept   = r_state == IDLE || (r_state == WAIT && lcd_busy);
  assign w_take     = w_accept && (r_skid_full || w_valid);
  assign w_take_val = r_skid_full ? r_skid_val : w_din;
  assign w_full     = r_count == C_DEPTH;
  assign w_zero     = r_samp == '0;
  assign w_avg      = r_sum[SW-1:LOG2_DEPTH];
  assign w_target   = w_zero ? '0 : w_avg;
  assign w_has      = w_zero || w_full;
  assign w_diff     = w_target >= r_shown ? w_target - r_shown : r_shown - w_target;
  assign w_trig     = w_has && (w_diff > C_HYST || (w_target == '0 && r_shown != '0));
  assign w_pend_any = (r_state == CMP && w_trig) || r_pend;
  assign w_pend_nxt = (r_state == CMP && w_trig) ? w_target : r_pend_val;
  assign update     = r_state == EMIT && !lcd_busy;
  assign freq_out   = r_freq_out;
  assign filled     = r_filled;

  // Next-state: a busy LCD parks a pending value in WAIT, which can still absorb samples.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_take ? SUM : IDLE;
      SUM:     w_next = CMP;
      CMP:     w_next = w_pend_any ? (lcd_busy ? WAIT : EMIT) : IDLE;
      WAIT:    w_next = !lcd_busy ? EMIT : (w_take ? SUM : WAIT);
      EMIT:    w_next = lcd_busy ? WAIT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sample window storage; contents are irrelevant until count says they are valid.
  always_ff @(posedge clk) begin
    if (r_state == SUM && !w_zero) r_buf[r_wr] <= r_samp;
  end

  // Control, running sum, skid, hysteresis bookkeeping and timeout counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_count     <= '0;
      r_wr        <= '0;
      r_samp      <= '0;
      r_skid_full <= 1'b0;
      r_skid_val  <= '0;
      r_shown     <= '0;
      r_pend      <= 1'b0;
      r_pend_val  <= '0;
      r_freq_out  <= '0;
      r_filled    <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (freq_valid || w_tmo || r_shown == '0) ? '0 : r_tmo + 24'd1;
      if (w_valid) r_skid_val <= w_din;
      r_skid_full <= w_accept ? (r_skid_full && w_valid) : (r_skid_full || w_valid);
      if (w_take) r_samp <= w_take_val;
      if (r_state == SUM) begin
        if (w_zero) begin
          r_sum    <= '0;
          r_count  <= '0;
          r_wr     <= '0;
          r_filled <= 1'b0;
        end else begin
          r_sum    <= r_sum + SW'(r_samp) - (w_full ? SW'(r_buf[r_wr]) : '0);
          r_wr     <= r_wr + 1'b1;
          r_count  <= w_full ? r_count : r_count + 1'b1;
          r_filled <= w_full || r_count == C_DEPTH - 1'b1;
        end
      end
      if (r_state == CMP) begin
        r_pend     <= w_pend_any;
        r_pend_val <= w_pend_nxt;
      end
      if ((r_state == CMP || r_state == WAIT) && w_next == EMIT) r_freq_out <= w_pend_nxt;
      if (update) begin
        r_shown <= r_pend_val;
        r_pend  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_freq_smoother.sv
// tb_freq_smoother: scoreboard bench for freq_smoother against a window/hysteresis reference model
module tb_freq_smoother;
  localparam int W = 16, L = 2, D = 4, H = 2;

  logic         clk = 0, reset = 0, freq_valid = 0, lcd_busy = 0;
  logic [W-1:0] freq_in = '0, freq_out;
  logic         update, filled;

  int n_chk = 0, n_fail = 0;

  typedef struct { int f; bit fl; } exp_t;
  exp_t q[$];
  exp_t e;
  int   win[$];
  int   m_shown = 0, m_pend_val = 0;
  bit   m_pend = 0, prev_upd = 0;

  freq_smoother #(.WIDTH(W), .LOG2_DEPTH(L), .HYST(H), .TIMEOUT(24'd200)) dut (
    .clk(clk), .reset(reset), .freq_in(freq_in), .freq_valid(freq_valid),
    .lcd_busy(lcd_busy), .freq_out(freq_out), .update(update), .filled(filled)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void m_reset();
    win.delete();
    q.delete();
    m_shown = 0; m_pend = 0; m_pend_val = 0;
  endfunction

  function automatic void m_release();
    if (m_pend) begin
      q.push_back('{m_pend_val, win.size() == D});
      m_shown = m_pend_val;
      m_pend  = 0;
    end
  endfunction

  function automatic void m_sample(input int v, input bit busy);
    int tgt = 0;
    bit has = 0;
    int dif;
    if (v == 0) begin
      win.delete();
      has = 1;
    end else begin
      win.push_back(v);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        tgt = win.sum() / D;
        has = 1;
      end
    end
    dif = tgt > m_shown ? tgt - m_shown : m_shown - tgt;
    if (has && (dif > H || (tgt == 0 && m_shown != 0))) begin
      m_pend = 1;
      m_pend_val = tgt;
    end
    if (!busy) m_release();
  endfunction

  // Monitor: every update strobe is matched against the oldest expected display value.
  always @(negedge clk) begin
    if (reset && update) begin
      check("update_while_busy", lcd_busy, 0);
      check("update_back_to_back", prev_upd, 0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_update: freq_out=%0d with nothing expected", freq_out);
      end else begin
        e = q.pop_front();
        check("freq_out", freq_out, e.f);
        check("filled_at_update", filled, e.fl);
      end
    end
    prev_upd = update;
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 0; lcd_busy = 0; freq_valid = 0;
    @(posedge clk); #1 reset = 1;
    m_reset();
  endtask

  task automatic strobe(input int v);
    @(posedge clk); #1 freq_in = W'(v); freq_valid = 1;
    @(posedge clk); #1 freq_valid = 0;
  endtask

  task automatic send(input int v, input int gap);
    strobe(v);
    m_sample(v, lcd_busy);
    repeat (gap) @(posedge clk);
  endtask

  task automatic burst(input int a, input int b, input int c, input bit three);
    @(posedge clk); #1 freq_in = W'(a); freq_valid = 1;
    @(posedge clk); #1 freq_in = W'(b);
    if (three) begin
      @(posedge clk); #1 freq_in = W'(c);
    end
    @(posedge clk); #1 freq_valid = 0;
  endtask

  task automatic drain(input string name, input int cyc);
    repeat (cyc) @(posedge clk);
    check(name, q.size(), 0);
  endtask

  task automatic wait_update(input string name, input int exp_lat);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!update && lat < 12);
    check(name, lat, exp_lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int base, v;
    do_reset();
    @(negedge clk);
    check("reset_freq_out", freq_out, 0);
    check("reset_update", update, 0);
    check("reset_filled", filled, 0);

    repeat (3) send(253, 3);
    check("filled_before_4th", filled, 0);
    strobe(253);
    m_sample(253, 0);
    wait_update("latency_first_update", 3);
    check("filled_after_4th", filled, 1);
    drain("t1_queue", 10);

    send(254, 4);
    repeat (4) send(300, 4);
    drain("t2_queue", 10);
    check("t2_final_freq_out", freq_out, 300);

    do_reset();
    lcd_busy = 1;
    repeat (4) send(253, 4);
    repeat (50) @(posedge clk);
    #1 lcd_busy = 0;
    m_release();
    wait_update("busy_release_latency", 2);
    drain("t3_queue", 10);

    do_reset();
    repeat (4) send(440, 4);
    send(0, 6);
    check("t4_filled_after_zero", filled, 0);
    repeat (3) send(440, 4);
    send(440, 4);
    drain("t4_queue", 10);

    do_reset();
    repeat (3) send(100, 4);
    burst(1000, 7, 2000, 1);
    m_sample(1000, 0);
    m_sample(2000, 0);
    drain("t5_three_strobes", 15);
    burst(50, 60, 0, 0);
    m_sample(50, 0);
    m_sample(60, 0);
    drain("t5_two_strobes", 15);

    do_reset();
    repeat (4) send(300, 4);
    m_sample(0, 0);
    drain("t6_timeout_fired", 260);
    check("t6_freq_out_zero", freq_out, 0);
    drain("t6_no_repeat", 500);

    lcd_busy = 1;
    repeat (4) send(300, 4);
    repeat (5) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1 reset = 1; lcd_busy = 0;
    m_reset();
    @(negedge clk);
    check("rst_wait_freq_out", freq_out, 0);
    check("rst_wait_update", update, 0);
    check("rst_wait_filled", filled, 0);
    drain("rst_wait_no_update", 20);

    do_reset();
    base = 400;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) base = $urandom_range(50, 2000);
      v = ($urandom_range(0, 11) == 0) ? 0 : base + $urandom_range(0, 6);
      if ($urandom_range(0, 4) == 0) begin
        lcd_busy = ~lcd_busy;
        if (!lcd_busy) m_release();
      end
      send(v, $urandom_range(3, 6));
    end
    lcd_busy = 0;
    m_release();
    drain("random_queue", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
